count111_stim_tx: RTL and testbench

- Transmit-side counterpart of the 111-run detector path: serialises parallel words onto a single-bit line that an asynchronous receiver captures through a 2-FF synchronizer.
- Each bit is held for HOLD_CYC clk cycles from a registered, glitch-free output, so the far-end synchronizer samples it reliably.
- Each frame is followed by a forced-low gap, so runs of ones never merge across frames.
- Also reports the number of overlapping "111" windows it transmitted; this is the reference count for the downstream FSM result.

---
 rtl/count111_stim_tx.sv | 121 ++++++++++++
 tb/tb_count111_stim_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/count111_stim_tx.sv
// count111_stim_tx: serialises words MSB-first onto a held, registered line with a forced-low gap and counts emitted "111" windows
module count111_stim_tx #(
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 3,
    parameter int GAP_CYC  = 4,
    parameter int RUN_W    = 4
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic              tx_bit,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [RUN_W-1:0]  run_count
);
    localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
    localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] sh, sh_nx;
    logic [HW-1:0]     hold, hold_nx;
    logic [GW-1:0]     gap, gap_nx;
    logic [BW-1:0]     bidx, bidx_nx;
    logic [1:0]        hist, hist_nx;
    logic              tx_nx, done_nx, aborted_nx;
    logic [RUN_W-1:0]  run_nx;
    logic              hold_last, bit_last, gap_last, nb;

    assign hold_last = hold == HW'(HOLD_CYC - 1);
    assign bit_last  = bidx == BW'(DATA_W - 1);
    assign gap_last  = gap == GW'(GAP_CYC - 1);
    assign nb        = sh[DATA_W-1];
    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;

    // next-state: sh holds the not-yet-launched bits MSB-aligned, hist the last two launched bits
    always_comb begin
        state_nx   = state;
        sh_nx      = sh;
        hold_nx    = hold;
        gap_nx     = gap;
        bidx_nx    = bidx;
        hist_nx    = hist;
        tx_nx      = tx_bit;
        done_nx    = 1'b0;
        aborted_nx = aborted;
        run_nx     = run_count;
        case (state)
            IDLE: if (in_valid) begin
                state_nx   = SHIFT;
                sh_nx      = {in_data[DATA_W-2:0], 1'b0};
                hold_nx    = '0;
                bidx_nx    = '0;
                hist_nx    = {1'b0, in_data[DATA_W-1]};
                tx_nx      = in_data[DATA_W-1];
                aborted_nx = 1'b0;
                run_nx     = '0;
            end
            SHIFT: if (abort) begin
                state_nx   = GAP;
                gap_nx     = '0;
                tx_nx      = 1'b0;
                aborted_nx = 1'b1;
            end else if (!hold_last) begin
                hold_nx = hold + 1'b1;
            end else if (bit_last) begin
                state_nx = GAP;
                gap_nx   = '0;
                tx_nx    = 1'b0;
            end else begin
                hold_nx = '0;
                bidx_nx = bidx + 1'b1;
                tx_nx   = nb;
                sh_nx   = sh << 1;
                hist_nx = {hist[0], nb};
                run_nx  = (nb && &hist && run_count != '1) ? run_count + 1'b1 : run_count;
            end
            GAP: if (gap_last) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end else begin
                gap_nx = gap + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state and datapath registers; reset drops the line at once and suppresses done
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            gap       <= '0;
            bidx      <= '0;
            hist      <= '0;
            tx_bit    <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            run_count <= '0;
        end else begin
            state     <= state_nx;
            sh        <= sh_nx;
            hold      <= hold_nx;
            gap       <= gap_nx;
            bidx      <= bidx_nx;
            hist      <= hist_nx;
            tx_bit    <= tx_nx;
            done      <= done_nx;
            aborted   <= aborted_nx;
            run_count <= run_nx;
        end
    end
endmodule

// File: tb/tb_count111_stim_tx.sv
// tb_count111_stim_tx: frame-level model plus directed literal checks for count111_stim_tx
module tb_count111_stim_tx;
    localparam int DW = 8;
    localparam int G  = 4;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst_p = 1'b1;
    logic [7:0] d3 = '0, d1 = '0;
    logic v3 = 1'b0, v1 = 1'b0, a3 = 1'b0, a1 = 1'b0;
    logic rdy3, tx3, busy3, done3, ab3;
    logic rdy1, tx1, busy1, done1, ab1;
    logic [RW-1:0] rc3, rc1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    count111_stim_tx #(.DATA_W(DW), .HOLD_CYC(3), .GAP_CYC(G), .RUN_W(RW)) dut (
        .clk(clk), .rst_p(rst_p), .in_data(d3), .in_valid(v3), .in_ready(rdy3), .abort(a3),
        .tx_bit(tx3), .busy(busy3), .done(done3), .aborted(ab3), .run_count(rc3));

    count111_stim_tx #(.DATA_W(DW), .HOLD_CYC(1), .GAP_CYC(G), .RUN_W(RW)) dut_h1 (
        .clk(clk), .rst_p(rst_p), .in_data(d1), .in_valid(v1), .in_ready(rdy1), .abort(a1),
        .tx_bit(tx1), .busy(busy1), .done(done1), .aborted(ab1), .run_count(rc1));

    // A frame is described by its acceptance edge e, the edge s where the line goes low
    // (end of bits or abort), and the edge fin where it returns to idle.
    typedef struct {
        bit act, ever, ab, dn;
        int e, s, fin;
        logic [7:0] w;
    } frm_t;

    frm_t f3 = '{default: 0};
    frm_t f1 = '{default: 0};
    int n = 0;

    function automatic frm_t step(frm_t f, int k, bit v, bit a, logic [7:0] d, int h);
        frm_t r = f;
        r.dn = 1'b0;
        if (f.act && k == f.fin) begin
            r.act = 1'b0;
            r.dn  = 1'b1;
        end else if (!f.act && v) begin
            r.act = 1'b1; r.ever = 1'b1; r.ab = 1'b0;
            r.e = k; r.s = k + DW * h; r.fin = r.s + G; r.w = d;
        end else if (f.act && a && k > f.e && k <= f.s) begin
            r.s = k; r.fin = k + G; r.ab = 1'b1;
        end
        return r;
    endfunction

    function automatic int runs(frm_t f, int k, int h);
        int last;
        int c = 0;
        if (!f.ever) return 0;
        last = ((k < f.s ? k : f.s - 1) - f.e) / h;
        for (int b = 2; b <= last && b < DW; b++)
            if (f.w[DW-1-b] && f.w[DW-b] && f.w[DW+1-b]) c = c < (1 << RW) - 1 ? c + 1 : c;
        return c;
    endfunction

    function automatic bit txe(frm_t f, int k, int h);
        return f.act && k < f.s ? f.w[DW-1-(k-f.e)/h] : 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // model advances one frame-level step per clock edge from the sampled inputs
    always @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            f3 <= '{default: 0};
            f1 <= '{default: 0};
        end else begin
            n  <= n + 1;
            f3 <= step(f3, n + 1, v3, a3, d3, 3);
            f1 <= step(f1, n + 1, v1, a1, d1, 1);
        end
    end

    // every cycle out of reset, both instances against the model
    always @(negedge clk) begin
        if (!rst_p) begin
            chk("h3 tx_bit", tx3, txe(f3, n, 3));
            chk("h3 in_ready", rdy3, !f3.act);
            chk("h3 busy", busy3, f3.act);
            chk("h3 done", done3, f3.dn);
            chk("h3 aborted", ab3, f3.ab);
            chk("h3 run_count", rc3, runs(f3, n, 3));
            chk("h1 tx_bit", tx1, txe(f1, n, 1));
            chk("h1 in_ready", rdy1, !f1.act);
            chk("h1 busy", busy1, f1.act);
            chk("h1 done", done1, f1.dn);
            chk("h1 aborted", ab1, f1.ab);
            chk("h1 run_count", rc1, runs(f1, n, 1));
        end
    end

    task automatic go(input bit sel, input logic [7:0] d);
        if (sel) begin d1 = d; v1 = 1'b1; end
        else begin d3 = d; v3 = 1'b1; end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v3 = 1'b0;
    endtask

    // record the line for cycles 1..nc after acceptance, pulsing abort in cycle abc
    task automatic cap(input bit sel, input int nc, input int abc, output logic [63:0] seq,
                       output int dat, output int dcnt, output logic [3:0] rcd, output logic abd);
        seq = '0; dat = 0; dcnt = 0; rcd = '0; abd = 1'b0;
        for (int c = 1; c <= nc; c++) begin
            @(negedge clk);
            if (sel) a1 = (c == abc); else a3 = (c == abc);
            seq[c-1] = sel ? tx1 : tx3;
            if (sel ? done1 : done3) begin
                dcnt++;
                if (dat == 0) begin
                    dat = c;
                    rcd = sel ? rc1 : rc3;
                    abd = sel ? ab1 : ab3;
                end
            end
        end
        a1 = 1'b0;
        a3 = 1'b0;
    endtask

    logic [63:0] seq;
    int dat, dcnt;
    logic [3:0] rcd;
    logic abd;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset in_ready", rdy3, 1);
        chk("reset tx_bit", tx3, 0);
        chk("reset busy", busy3, 0);
        chk("reset done", done3, 0);
        chk("reset aborted", ab3, 0);
        chk("reset run_count", rc3, 0);
        @(posedge clk);
        #1 rst_p = 1'b0;
        @(negedge clk);

        go(0, 8'b1110_0111);
        cap(0, 29, 0, seq, dat, dcnt, rcd, abd);
        chk("E7 line", seq[27:0], 28'h0FF81FF);
        chk("E7 done cycle", dat, 29);
        chk("E7 done count", dcnt, 1);
        chk("E7 run_count", rcd, 2);
        chk("E7 aborted", abd, 0);

        go(0, 8'hFF);
        cap(0, 29, 0, seq, dat, dcnt, rcd, abd);
        chk("FF line", seq[27:0], 28'h0FFFFFF);
        chk("FF done cycle", dat, 29);
        chk("FF run_count", rcd, 6);
        go(0, 8'h00);
        cap(0, 29, 0, seq, dat, dcnt, rcd, abd);
        chk("00 line", seq[28:0], 29'h0);
        chk("00 done cycle", dat, 29);
        chk("00 run_count", rcd, 0);

        d3 = 8'hA5;
        v3 = 1'b1;
        @(posedge clk);
        #1 d3 = 8'h3C;
        cap(0, 29, 0, seq, dat, dcnt, rcd, abd);
        chk("A5 line", seq[27:0], 28'h0E381C7);
        chk("A5 done cycle", dat, 29);
        chk("A5 run_count", rcd, 0);
        @(posedge clk);
        #1 v3 = 1'b0;
        cap(0, 29, 0, seq, dat, dcnt, rcd, abd);
        chk("3C line", seq[27:0], 28'h003FFC0);
        chk("3C done cycle", dat, 29);
        chk("3C run_count", rcd, 2);

        go(0, 8'hF0);
        cap(0, 13, 8, seq, dat, dcnt, rcd, abd);
        chk("F0 abort line", seq[11:0], 12'h0FF);
        chk("F0 abort done cycle", dat, 13);
        chk("F0 abort run_count", rcd, 1);
        chk("F0 aborted", abd, 1);

        go(0, 8'hFF);
        cap(0, 29, 24, seq, dat, dcnt, rcd, abd);
        chk("last-bit abort done cycle", dat, 29);
        chk("last-bit abort run_count", rcd, 6);
        chk("last-bit aborted", abd, 1);

        go(0, 8'h07);
        cap(0, 29, 26, seq, dat, dcnt, rcd, abd);
        chk("gap abort done cycle", dat, 29);
        chk("gap abort run_count", rcd, 1);
        chk("gap abort ignored", abd, 0);

        go(0, 8'hFF);
        repeat (10) @(negedge clk);
        #2 rst_p = 1'b1;
        #1;
        chk("midframe reset tx_bit", tx3, 0);
        chk("midframe reset busy", busy3, 0);
        chk("midframe reset in_ready", rdy3, 1);
        @(posedge clk);
        #1 rst_p = 1'b0;
        cap(0, 35, 0, seq, dat, dcnt, rcd, abd);
        chk("post-reset no done", dcnt, 0);
        chk("post-reset line low", seq[34:0], 35'h0);
        go(0, 8'b1110_0111);
        cap(0, 29, 0, seq, dat, dcnt, rcd, abd);
        chk("post-reset E7 line", seq[27:0], 28'h0FF81FF);
        chk("post-reset E7 done cycle", dat, 29);
        chk("post-reset E7 run_count", rcd, 2);

        go(1, 8'b1011_1101);
        cap(1, 13, 0, seq, dat, dcnt, rcd, abd);
        chk("hold1 line", seq[11:0], 12'h0BD);
        chk("hold1 done cycle", dat, 13);
        chk("hold1 run_count", rcd, 2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
